ddr3_cmd_responder: RTL and testbench

- Decodes the DDR3 command bus driven by the HPS SDRAM controller, seen from the memory side, sampled once per cycle on the controller clock.
- Tracks per-bank open/closed state and open row.
- Checks core bank timing (tRCD, tRP, tRAS) and protocol legality.
- Reports decoded commands and violations to fabric debug logic, e.g. an LED/PIO export or an error counter readable over a PIO.

---
 rtl/ddr3_resp_pkg.sv | 33 +++
 rtl/ddr3_bank_tracker.sv | 44 ++++
 rtl/ddr3_cmd_responder.sv | 136 +++++++++++++
 tb/tb_ddr3_cmd_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ddr3_resp_pkg.sv
// Shared types for the DDR3 command responder: decoded command and violation codes.
package ddr3_resp_pkg;

    localparam int             TIMER_W   = 5;
    localparam logic [4:0]     TIMER_MAX = 5'd31;
    localparam int             NUM_BANKS = 8;

    typedef enum logic [3:0] {
        DES  = 4'd0,
        NOP  = 4'd1,
        ACT  = 4'd2,
        RD   = 4'd3,
        RDA  = 4'd4,
        WR   = 4'd5,
        WRA  = 4'd6,
        PRE  = 4'd7,
        PREA = 4'd8,
        REF  = 4'd9,
        MRS  = 4'd10,
        ZQC  = 4'd11
    } cmd_e;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        ERR_ACT_OPEN = 3'd1,
        ERR_RW_IDLE  = 3'd2,
        ERR_TRCD     = 3'd3,
        ERR_TRAS     = 3'd4,
        ERR_TRP      = 3'd5,
        ERR_REF_OPEN = 3'd6
    } err_e;

endpackage

// File: rtl/ddr3_bank_tracker.sv
// One bank's open/closed flag, open row and cycles-since-ACT/PRE timer.
module ddr3_bank_tracker
    import ddr3_resp_pkg::*;
#(
    parameter int ROW_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               act,
    input  logic               pre,
    input  logic               rdwr,
    input  logic               auto_pre,
    input  logic [ROW_W-1:0]   row_in,
    output logic               active,
    output logic [TIMER_W-1:0] timer,
    output logic [ROW_W-1:0]   row
);

    logic close_evt;

    // RDA/WRA close the bank exactly like an explicit PRE
    assign close_evt = pre | (rdwr & auto_pre);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            row    <= '0;
            timer  <= TIMER_MAX;
        end else begin
            if (act) begin
                active <= 1'b1;
                row    <= row_in;
            end else if (close_evt) begin
                active <= 1'b0;
            end

            if (act || close_evt)
                timer <= TIMER_W'(1);
            else if (timer != TIMER_MAX)
                timer <= timer + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_cmd_responder.sv
// Memory-side DDR3 command decoder with per-bank timing/protocol checking.
module ddr3_cmd_responder
    import ddr3_resp_pkg::*;
#(
    parameter int TRCD  = 5,
    parameter int TRP   = 5,
    parameter int TRAS  = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             mem_cke,
    input  logic             mem_cs_n,
    input  logic             mem_ras_n,
    input  logic             mem_cas_n,
    input  logic             mem_we_n,
    input  logic [2:0]       mem_ba,
    input  logic [12:0]      mem_a,
    output logic             cmd_valid,
    output logic [3:0]       cmd_code,
    output logic [2:0]       cmd_bank,
    output logic [12:0]      cmd_addr,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       bank_open
);

    localparam logic [TIMER_W-1:0] TRCD_T = TIMER_W'(TRCD);
    localparam logic [TIMER_W-1:0] TRP_T  = TIMER_W'(TRP);
    localparam logic [TIMER_W-1:0] TRAS_T = TIMER_W'(TRAS);

    cmd_e                             cmd;
    err_e                             err;
    logic                             is_rw;
    logic                             auto_pre;
    logic                             tras_viol;
    logic [NUM_BANKS-1:0]             active;
    logic [NUM_BANKS-1:0][TIMER_W-1:0] timer;
    logic [NUM_BANKS-1:0][12:0]       rows;
    logic                             unused_rows;

    // Open rows are kept per bank for debug probing but not exported
    assign unused_rows = ^rows;

    always_comb begin
        cmd = NOP;
        if (mem_cke) begin
            if (mem_cs_n) begin
                cmd = DES;
            end else begin
                case ({mem_ras_n, mem_cas_n, mem_we_n})
                    3'b111:  cmd = NOP;
                    3'b011:  cmd = ACT;
                    3'b101:  cmd = mem_a[10] ? RDA  : RD;
                    3'b100:  cmd = mem_a[10] ? WRA  : WR;
                    3'b010:  cmd = mem_a[10] ? PREA : PRE;
                    3'b001:  cmd = REF;
                    3'b000:  cmd = MRS;
                    default: cmd = ZQC;
                endcase
            end
        end
    end

    assign is_rw    = (cmd == RD) || (cmd == RDA) || (cmd == WR) || (cmd == WRA);
    assign auto_pre = (cmd == RDA) || (cmd == WRA);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic hit;
        assign hit = (mem_ba == 3'(i));

        ddr3_bank_tracker #(.ROW_W(13)) u_bank (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .act      ((cmd == ACT) && hit),
            .pre      (((cmd == PRE) && hit) || (cmd == PREA)),
            .rdwr     (is_rw && hit),
            .auto_pre (auto_pre),
            .row_in   (mem_a),
            .active   (active[i]),
            .timer    (timer[i]),
            .row      (rows[i])
        );
    end

    always_comb begin
        tras_viol = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (((cmd == PREA) || ((cmd == PRE) && (mem_ba == 3'(i)))) &&
                active[i] && (timer[i] < TRAS_T))
                tras_viol = 1'b1;
        end
    end

    // Checks use pre-command bank state; first match wins
    always_comb begin
        err = NONE;
        if ((cmd == ACT) && active[mem_ba])
            err = ERR_ACT_OPEN;
        else if (is_rw && !active[mem_ba])
            err = ERR_RW_IDLE;
        else if (is_rw && (timer[mem_ba] < TRCD_T))
            err = ERR_TRCD;
        else if (tras_viol)
            err = ERR_TRAS;
        else if ((cmd == ACT) && (timer[mem_ba] < TRP_T))
            err = ERR_TRP;
        else if (((cmd == REF) || (cmd == MRS)) && (|active))
            err = ERR_REF_OPEN;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            err_count <= '0;
        end else begin
            cmd_valid <= (cmd != NOP) && (cmd != DES);
            cmd_code  <= cmd;
            cmd_bank  <= mem_ba;
            cmd_addr  <= mem_a;
            err_valid <= (err != NONE);
            err_code  <= err;
            if ((err != NONE) && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + CNT_W'(1);
        end
    end

    assign bank_open = active;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: timing violations, bank tracking, reset, counter saturation.
module tb_ddr3_cmd_responder;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_ZQC = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [12:0] a  = '0;

    logic        cmd_valid, err_valid;
    logic [3:0]  cmd_code;
    logic [2:0]  cmd_bank, err_code;
    logic [12:0] cmd_addr;
    logic [15:0] err_count;
    logic [7:0]  bank_open;

    logic        s_cmd_valid, s_err_valid;
    logic [3:0]  s_cmd_code;
    logic [2:0]  s_cmd_bank, s_err_code;
    logic [12:0] s_cmd_addr;
    logic [3:0]  s_err_count;
    logic [7:0]  s_bank_open;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ddr3_cmd_responder #(.TRCD(5), .TRP(5), .TRAS(15), .CNT_W(16)) dut (
        .clk_clk(clk), .reset_reset(rst), .mem_cke(cke), .mem_cs_n(cs_n),
        .mem_ras_n(ras_n), .mem_cas_n(cas_n), .mem_we_n(we_n), .mem_ba(ba), .mem_a(a),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .err_valid(err_valid), .err_code(err_code), .err_count(err_count), .bank_open(bank_open)
    );

    // Narrow-counter copy on the same bus to exercise saturation in few cycles
    ddr3_cmd_responder #(.TRCD(5), .TRP(5), .TRAS(15), .CNT_W(4)) dut_sat (
        .clk_clk(clk), .reset_reset(rst), .mem_cke(cke), .mem_cs_n(cs_n),
        .mem_ras_n(ras_n), .mem_cas_n(cas_n), .mem_we_n(we_n), .mem_ba(ba), .mem_a(a),
        .cmd_valid(s_cmd_valid), .cmd_code(s_cmd_code), .cmd_bank(s_cmd_bank), .cmd_addr(s_cmd_addr),
        .err_valid(s_err_valid), .err_code(s_err_code), .err_count(s_err_count), .bank_open(s_bank_open)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [12:0] ad);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b;
        a  = ad;
        @(posedge clk); #1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        a = '0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #12;
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_bank_open", 32'(bank_open), 0);
        chk("rst_err_count", 32'(err_count), 0);
        @(negedge clk); rst = 1'b0;

        // first-cycle ACT after reset is legal
        issue(C_ACT, 3'd2, 13'h0ABC);
        chk("act_valid", 32'(cmd_valid), 1);
        chk("act_code",  32'(cmd_code), 2);
        chk("act_bank",  32'(cmd_bank), 2);
        chk("act_addr",  32'(cmd_addr), 32'h0ABC);
        chk("act_open",  32'(bank_open), 32'h04);
        chk("act_noerr", 32'(err_valid), 0);

        // tRCD: RD at k=4 fails, k=5 passes
        issue(C_ACT, 3'd1, 13'h0011);
        nop(3);
        issue(C_RD, 3'd1, 13'h0020);
        chk("trcd_err_valid", 32'(err_valid), 1);
        chk("trcd_code",  32'(err_code), 3);
        chk("trcd_count", 32'(err_count), 1);
        chk("rd_code",    32'(cmd_code), 3);
        issue(C_RD, 3'd1, 13'h0020);
        chk("trcd_ok",       32'(err_valid), 0);
        chk("trcd_ok_count", 32'(err_count), 1);

        // tRAS at k=14, then tRP two cycles after PRE
        issue(C_ACT, 3'd0, 13'h0100);
        nop(13);
        issue(C_PRE, 3'd0, 13'h0000);
        chk("tras_code",  32'(err_code), 4);
        chk("tras_open",  32'(bank_open), 32'h06);
        chk("tras_count", 32'(err_count), 2);
        nop(1);
        issue(C_ACT, 3'd0, 13'h0100);
        chk("trp_code",  32'(err_code), 5);
        chk("trp_count", 32'(err_count), 3);
        chk("trp_open",  32'(bank_open), 32'h07);

        // RD to idle bank, REF with banks open, then clean PREA
        issue(C_RD, 3'd3, 13'h0008);
        chk("rw_idle_code", 32'(err_code), 2);
        issue(C_ACT, 3'd5, 13'h0055);
        chk("act5_noerr", 32'(err_valid), 0);
        chk("act5_open",  32'(bank_open), 32'h27);
        issue(C_REF, 3'd0, 13'h0000);
        chk("ref_code",  32'(err_code), 6);
        chk("ref_count", 32'(err_count), 5);
        nop(14);
        issue(C_PRE, 3'd0, 13'h0400);
        chk("prea_code",  32'(cmd_code), 8);
        chk("prea_noerr", 32'(err_valid), 0);
        chk("prea_open",  32'(bank_open), 0);

        // WRA at k=5 closes the bank; ACT 4 cycles later hits tRP
        nop(5);
        issue(C_ACT, 3'd6, 13'h0066);
        chk("act6_noerr", 32'(err_valid), 0);
        nop(4);
        issue(C_WR, 3'd6, 13'h0410);
        chk("wra_code",  32'(cmd_code), 6);
        chk("wra_noerr", 32'(err_valid), 0);
        chk("wra_open",  32'(bank_open), 0);
        nop(3);
        issue(C_ACT, 3'd6, 13'h0066);
        chk("wra_trp_code",  32'(err_code), 5);
        chk("wra_trp_count", 32'(err_count), 6);
        chk("wra_trp_open",  32'(bank_open), 32'h40);

        // cke low masks an ACT encoding
        cke = 1'b0;
        issue(C_ACT, 3'd7, 13'h0077);
        cke = 1'b1;
        chk("cke_valid", 32'(cmd_valid), 0);
        chk("cke_err",   32'(err_valid), 0);
        chk("cke_open",  32'(bank_open), 32'h40);

        issue(C_ACT, 3'd0, 13'h0001);
        issue(C_ACT, 3'd3, 13'h0003);
        chk("open3", 32'(bank_open), 32'h49);
        issue(C_ZQC, 3'd0, 13'h0000);
        chk("zqc_code",  32'(cmd_code), 11);
        chk("zqc_noerr", 32'(err_valid), 0);
        issue(C_MRS, 3'd0, 13'h0000);
        chk("mrs_code",  32'(err_code), 6);
        chk("mrs_count", 32'(err_count), 7);
        chk("sat_pre",   32'(s_err_count), 7);

        // back-to-back ACT to an open bank: one error per cycle
        repeat (10) issue(C_ACT, 3'd0, 13'h0001);
        chk("act_open_code", 32'(err_code), 1);
        chk("count_17",      32'(err_count), 17);
        chk("sat_hold",      32'(s_err_count), 15);

        // async reset with three banks open
        rst = 1'b1;
        #1;
        chk("mid_rst_open",  32'(bank_open), 0);
        chk("mid_rst_count", 32'(err_count), 0);
        chk("mid_rst_sat",   32'(s_err_count), 0);
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        @(negedge clk); rst = 1'b0;
        issue(C_ACT, 3'd4, 13'h0044);
        chk("post_rst_valid", 32'(cmd_valid), 1);
        chk("post_rst_noerr", 32'(err_valid), 0);
        chk("post_rst_open",  32'(bank_open), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
